serial_rx: RTL



---
 rtl/serial_pkg.sv | 19 +
 rtl/sync_2ff.sv | 28 ++
 rtl/serial_rx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial line receive/transmit blocks.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

    localparam logic LINE_IDLE = 1'b1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/serial_rx.sv
// Serial frame receiver: start/DW data (LSB first)/stop, OVS clocks per bit,
// mid-bit sampling, one-cycle VLD or ERR pulse per frame.
module serial_rx
    import serial_pkg::*;
#(
    parameter int DW  = 8,
    parameter int OVS = 4
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          I,
    output logic [DW-1:0] O,
    output logic          VLD,
    output logic          ERR,
    output logic          BUSY
);

    localparam int TW = cnt_w(OVS);
    localparam int BW = cnt_w(DW + 1);
    localparam logic [TW-1:0] TICK_MID = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVS - 1);
    localparam logic [BW-1:0] BIT_END  = BW'(DW - 1);

    generate
        if (DW < 1 || DW > 16 || OVS < 4 || (OVS % 2) != 0) begin : g_bad_param
            $error("serial_rx: DW must be 1..16 and OVS even and >= 4");
        end
    endgenerate

    logic s;

    sync_2ff #(.RST_VAL(LINE_IDLE)) u_sync (
        .clk   (CLK),
        .rst_n (RSTN),
        .d     (I),
        .q     (s)
    );

    rx_state_e     state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic [DW-1:0] o_q, o_d;
    logic [2:0]    vld_pipe_q, vld_pipe_d;
    logic [2:0]    err_pipe_q, err_pipe_d;
    logic          busy_q, busy_d;
    logic          ok_stop, bad_stop;

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        ok_stop  = 1'b0;
        bad_stop = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (s == 1'b0) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (tick_q == TICK_MID) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = s ? IDLE : DATA;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            DATA: begin
                if (tick_q == TICK_END) begin
                    // Shifting in from the top leaves bit 0 at the LSB after DW samples.
                    shreg_d = (shreg_q >> 1) | (DW'(s) << (DW - 1));
                    tick_d  = '0;
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BIT_END) begin
                        state_d = STOP;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            STOP: begin
                if (tick_q == TICK_END) begin
                    tick_d = '0;
                    if (s) begin
                        ok_stop = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bad_stop = 1'b1;
                        state_d  = BREAK;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            BREAK: begin
                if (s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);

        // The stop verdict is retired through a short pipe so VLD/ERR land at
        // the fixed frame latency; shreg is stable for longer than the pipe.
        vld_pipe_d = {vld_pipe_q[1:0], ok_stop};
        err_pipe_d = {err_pipe_q[1:0], bad_stop};
        o_d        = vld_pipe_q[1] ? shreg_q : o_q;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            o_q        <= '0;
            vld_pipe_q <= '0;
            err_pipe_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            o_q        <= o_d;
            vld_pipe_q <= vld_pipe_d;
            err_pipe_q <= err_pipe_d;
            busy_q     <= busy_d;
        end
    end

    assign O    = o_q;
    assign VLD  = vld_pipe_q[2];
    assign ERR  = err_pipe_q[2];
    assign BUSY = busy_q;

endmodule
